// File: rtl/spart_bus_arbiter_if.sv
// Client-side handshake bundle for one SPART bus client: request, access
// attributes and the grant/done/read-data returns.
interface spart_bus_arbiter_if;
  logic       req;
  logic       rw;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       gnt;
  logic       done;
  logic [7:0] rdata;

  modport master (output req, rw, addr, wdata, input gnt, done, rdata);
  modport slave  (input req, rw, addr, wdata, output gnt, done, rdata);
endinterface

// File: rtl/spart_bus_arbiter.sv
// Sole master of a SPART processor bus: programs the baud divisor after reset
// or br_cfg change, then grants round-robin single-cycle accesses to two clients.
//
// state   | meaning
// BOOT    | sample br_cfg into cfg_q
// INIT_LO | bus write of divisor low byte to DB low (10)
// INIT_HI | bus write of divisor high byte to DB high (11)
// IDLE    | watch for br_cfg change, arbitrate eligible client requests
// ACCESS  | granted client's bus cycle on iocs
// DONE    | bus released, done pulse scheduled for the served client
module spart_bus_arbiter #(
  parameter logic [15:0] DIV_4800  = 16'd651,
  parameter logic [15:0] DIV_9600  = 16'd325,
  parameter logic [15:0] DIV_19200 = 16'd162,
  parameter logic [15:0] DIV_38400 = 16'd81
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            br_cfg,
  spart_bus_arbiter_if.slave    c0,
  spart_bus_arbiter_if.slave    c1,
  output logic                  init_done,
  output logic                  iocs,
  output logic                  iorw,
  output logic [1:0]            ioaddr,
  inout  wire  [7:0]            databus,
  input  logic                  rda,
  input  logic                  tbr
);

  typedef enum logic [2:0] {BOOT, INIT_LO, INIT_HI, IDLE, ACCESS, DONE} state_t;

  state_t     state, state_d;
  logic [1:0] cfg_q, cfg_d;
  logic       rr_ptr, rr_d;
  logic       cur_client, cur_client_d;
  logic [7:0] dout, dout_d;
  logic       iocs_d, iorw_d, init_done_d;
  logic [1:0] ioaddr_d;
  logic       gnt0_d, gnt1_d, done0_d, done1_d;
  logic [7:0] rdata0_d, rdata1_d;
  logic       elig0, elig1, win;
  logic [15:0] div_boot, div_q;

  function automatic logic [15:0] div_of(input logic [1:0] sel);
    case (sel)
      2'b00:   div_of = DIV_4800;
      2'b01:   div_of = DIV_9600;
      2'b10:   div_of = DIV_19200;
      default: div_of = DIV_38400;
    endcase
  endfunction

  assign div_boot = div_of(br_cfg);
  assign div_q    = div_of(cfg_q);

  // Buffer accesses wait for the SPART to be ready so no character is lost.
  assign elig0 = c0.req & ~((c0.addr == 2'b00) & ~c0.rw & ~tbr)
                        & ~((c0.addr == 2'b00) &  c0.rw & ~rda);
  assign elig1 = c1.req & ~((c1.addr == 2'b00) & ~c1.rw & ~tbr)
                        & ~((c1.addr == 2'b00) &  c1.rw & ~rda);

  // rr_ptr names the client preferred on the next tie.
  assign win = (elig0 & elig1) ? rr_ptr : elig1;

  assign databus = (iocs && !iorw) ? dout : 8'hzz;

  always_comb begin
    state_d      = state;
    cfg_d        = cfg_q;
    rr_d         = rr_ptr;
    cur_client_d = cur_client;
    dout_d       = dout;
    ioaddr_d     = ioaddr;
    init_done_d  = init_done;
    iocs_d       = 1'b0;
    iorw_d       = 1'b1;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    rdata0_d     = c0.rdata;
    rdata1_d     = c1.rdata;
    case (state)
      BOOT: begin
        cfg_d    = br_cfg;
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = 2'b10;
        dout_d   = div_boot[7:0];
        state_d  = INIT_LO;
      end
      INIT_LO: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = 2'b11;
        dout_d   = div_q[15:8];
        state_d  = INIT_HI;
      end
      INIT_HI: begin
        init_done_d = 1'b1;
        ioaddr_d    = 2'b00;
        state_d     = IDLE;
      end
      IDLE: begin
        if (br_cfg != cfg_q) begin
          init_done_d = 1'b0;
          state_d     = BOOT;
        end else if (elig0 | elig1) begin
          rr_d         = ~win;
          cur_client_d = win;
          iocs_d       = 1'b1;
          iorw_d       = win ? c1.rw    : c0.rw;
          ioaddr_d     = win ? c1.addr  : c0.addr;
          dout_d       = win ? c1.wdata : c0.wdata;
          gnt0_d       = ~win;
          gnt1_d       = win;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (iorw && !cur_client) rdata0_d = databus;
        if (iorw &&  cur_client) rdata1_d = databus;
        state_d = DONE;
      end
      DONE: begin
        done0_d = ~cur_client;
        done1_d = cur_client;
        state_d = IDLE;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      cfg_q      <= 2'b00;
      rr_ptr     <= 1'b0;
      cur_client <= 1'b0;
      dout       <= 8'h00;
      iocs       <= 1'b0;
      iorw       <= 1'b1;
      ioaddr     <= 2'b00;
      init_done  <= 1'b0;
      c0.gnt     <= 1'b0;
      c1.gnt     <= 1'b0;
      c0.done    <= 1'b0;
      c1.done    <= 1'b0;
      c0.rdata   <= 8'h00;
      c1.rdata   <= 8'h00;
    end else begin
      state      <= state_d;
      cfg_q      <= cfg_d;
      rr_ptr     <= rr_d;
      cur_client <= cur_client_d;
      dout       <= dout_d;
      iocs       <= iocs_d;
      iorw       <= iorw_d;
      ioaddr     <= ioaddr_d;
      init_done  <= init_done_d;
      c0.gnt     <= gnt0_d;
      c1.gnt     <= gnt1_d;
      c0.done    <= done0_d;
      c1.done    <= done1_d;
      c0.rdata   <= rdata0_d;
      c1.rdata   <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Directed bench for spart_bus_arbiter: init sequence, round-robin, buffer
// hold-off, re-init on br_cfg change and reset mid-access.
module tb_spart_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b01;
  logic       init_done, iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  logic [7:0] sp_data = 8'h00;
  int         checks = 0;
  int         errors = 0;

  spart_bus_arbiter_if c0_if ();
  spart_bus_arbiter_if c1_if ();

  spart_bus_arbiter dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .c0(c0_if), .c1(c1_if),
    .init_done(init_done), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr)
  );

  // SPART register-file model: drives the bus on a selected read.
  assign databus = (iocs && iorw) ? sp_data : 8'hzz;

  always #10 clk = ~clk;

  typedef struct {
    logic       cl;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] sp;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cl, input logic req, input logic rw,
                       input logic [1:0] addr, input logic [7:0] wdata);
    if (cl) begin
      c1_if.req = req; c1_if.rw = rw; c1_if.addr = addr; c1_if.wdata = wdata;
    end else begin
      c0_if.req = req; c0_if.rw = rw; c0_if.addr = addr; c0_if.wdata = wdata;
    end
  endtask

  int gcyc[$];
  int gcl[$];

  initial begin
    drive(1'b0, 1'b0, 1'b1, 2'b00, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 2'b00, 8'h00);
    vecs[0] = '{1'b0, 1'b0, 2'b01, 8'hA5, 8'h00, 8'hA5};
    vecs[1] = '{1'b1, 1'b0, 2'b10, 8'h3C, 8'h00, 8'h3C};
    vecs[2] = '{1'b0, 1'b1, 2'b01, 8'h00, 8'h81, 8'h81};
    vecs[3] = '{1'b1, 1'b1, 2'b00, 8'h00, 8'h7E, 8'h7E};
    vecs[4] = '{1'b1, 1'b0, 2'b00, 8'h48, 8'h00, 8'h48};
    vecs[5] = '{1'b0, 1'b1, 2'b11, 8'h00, 8'h02, 8'h02};

    // Reset values
    #25;
    chk("rst_iocs", iocs, 0);
    chk("rst_iorw", iorw, 1);
    chk("rst_ioaddr", ioaddr, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_gnt0", c0_if.gnt, 0);
    chk("rst_done1", c1_if.done, 0);
    chk("rst_rdata0", c0_if.rdata, 0);

    // 1: boot init with br_cfg=01 (325 = 0x0145)
    @(negedge clk); rst = 1'b0;
    tick();
    chk("init_lo_iocs", iocs, 1);
    chk("init_lo_iorw", iorw, 0);
    chk("init_lo_addr", ioaddr, 2'b10);
    chk("init_lo_data", databus, 8'h45);
    chk("init_lo_done_flag", init_done, 0);
    tick();
    chk("init_hi_iocs", iocs, 1);
    chk("init_hi_addr", ioaddr, 2'b11);
    chk("init_hi_data", databus, 8'h01);
    tick();
    chk("init_end_iocs", iocs, 0);
    chk("init_done", init_done, 1);

    // 2: both clients held on status writes -> 0,1,0,1 every 3 cycles
    tbr = 1'b1; rda = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 2'b01, 8'h11);
    drive(1'b1, 1'b1, 1'b0, 2'b01, 8'h22);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (c0_if.gnt) begin gcyc.push_back(i); gcl.push_back(0); end
      if (c1_if.gnt) begin gcyc.push_back(i); gcl.push_back(1); end
    end
    drive(1'b0, 1'b0, 1'b0, 2'b01, 8'h11);
    drive(1'b1, 1'b0, 1'b0, 2'b01, 8'h22);
    chk("rr_grant_count", gcyc.size(), 4);
    for (int i = 0; i < 4 && i < gcyc.size(); i++) begin
      chk("rr_grant_client", gcl[i], i % 2);
      chk("rr_grant_cycle", gcyc[i], 1 + 3 * i);
    end
    repeat (4) tick();

    // Table-driven single accesses
    for (int v = 0; v < 6; v++) begin
      sp_data = vecs[v].sp;
      drive(vecs[v].cl, 1'b1, vecs[v].rw, vecs[v].addr, vecs[v].wdata);
      tick();
      chk("vec_gnt", vecs[v].cl ? c1_if.gnt : c0_if.gnt, 1);
      chk("vec_other_gnt", vecs[v].cl ? c0_if.gnt : c1_if.gnt, 0);
      chk("vec_iocs", iocs, 1);
      chk("vec_iorw", iorw, vecs[v].rw);
      chk("vec_ioaddr", ioaddr, vecs[v].addr);
      if (!vecs[v].rw) chk("vec_wbus", databus, vecs[v].exp);
      drive(vecs[v].cl, 1'b0, vecs[v].rw, vecs[v].addr, vecs[v].wdata);
      tick();
      chk("vec_done_iocs", iocs, 0);
      tick();
      chk("vec_done", vecs[v].cl ? c1_if.done : c0_if.done, 1);
      if (vecs[v].rw) chk("vec_rdata", vecs[v].cl ? c1_if.rdata : c0_if.rdata, vecs[v].exp);
    end
    chk("rdata1_held", c1_if.rdata, 8'h7E);

    // 3: buffer write held off while tbr=0
    tbr = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 2'b00, 8'h48);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tbr_hold_gnt0", c0_if.gnt, 0);
    end
    tbr = 1'b1;
    tick();
    chk("tbr_gnt0", c0_if.gnt, 1);
    chk("tbr_bus", databus, 8'h48);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 8'h48);
    tick(); tick();
    chk("tbr_done0", c0_if.done, 1);

    // 4: blocked read does not block the other client
    rda = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 2'b00, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 2'b01, 8'h5A);
    tick();
    chk("rda_gnt0_first", c0_if.gnt, 1);
    chk("rda_gnt1_blocked", c1_if.gnt, 0);
    drive(1'b0, 1'b0, 1'b0, 2'b01, 8'h5A);
    tick(); tick();
    chk("rda_done0", c0_if.done, 1);
    tick(); tick();
    chk("rda_still_blocked", c1_if.gnt, 0);
    rda = 1'b1; sp_data = 8'h65;
    tick();
    chk("rda_gnt1", c1_if.gnt, 1);
    drive(1'b1, 1'b0, 1'b1, 2'b00, 8'h00);
    tick(); tick();
    chk("rda_done1", c1_if.done, 1);
    chk("rda_rdata1", c1_if.rdata, 8'h65);

    // 5: br_cfg 01->11 while idle with a pending request (81 = 0x0051)
    br_cfg = 2'b11;
    drive(1'b0, 1'b1, 1'b0, 2'b01, 8'h33);
    tick();
    chk("reinit_drop", init_done, 0);
    chk("reinit_no_gnt", c0_if.gnt, 0);
    tick();
    chk("reinit_lo_addr", ioaddr, 2'b10);
    chk("reinit_lo_data", databus, 8'h51);
    tick();
    chk("reinit_hi_addr", ioaddr, 2'b11);
    chk("reinit_hi_data", databus, 8'h00);
    tick();
    chk("reinit_done", init_done, 1);
    chk("reinit_gnt_wait", c0_if.gnt, 0);
    tick();
    chk("reinit_gnt0", c0_if.gnt, 1);
    drive(1'b0, 1'b0, 1'b0, 2'b01, 8'h33);
    tick(); tick();
    chk("reinit_done0", c0_if.done, 1);

    // 6: reset during ACCESS
    drive(1'b0, 1'b1, 1'b0, 2'b10, 8'h99);
    tick();
    chk("rstmid_iocs_before", iocs, 1);
    drive(1'b0, 1'b0, 1'b0, 2'b10, 8'h99);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_iocs", iocs, 0);
    chk("rstmid_gnt0", c0_if.gnt, 0);
    chk("rstmid_init_done", init_done, 0);
    @(negedge clk); rst = 1'b0;
    tick();
    chk("rstmid_done0_a", c0_if.done, 0);
    chk("rstmid_lo_data", databus, 8'h51);
    chk("rstmid_lo_addr", ioaddr, 2'b10);
    tick();
    chk("rstmid_done0_b", c0_if.done, 0);
    chk("rstmid_hi_data", databus, 8'h00);
    tick();
    chk("rstmid_init_done_end", init_done, 1);
    chk("rstmid_done0_c", c0_if.done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
